// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the program counter, presents it to an
//   instruction ROM with combinational read, and forwards the returned word
//   to the decoder. A four-state controller decides when fetch is live.
//     WAIT  : one cycle after reset release, PC held
//     RUN   : normal fetch, PC advances by jump > branch > pc+4
//     HALT  : HALT_INSTR seen, fetch frozen until reset
//     FAULT : redirect to a non-word-aligned target, frozen until reset
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          freezes PC, state and retire count for the cycle
//   branch_taken   redirect to branch_target (lower priority than jump)
//   branch_target  branch destination byte address
//   jump           redirect to jump_target (highest priority)
//   jump_target    jump destination byte address
//   instr_in       ROM data for pc_out, valid in the same cycle
//   pc_out         current PC, ROM byte address
//   pc_plus4       pc_out + 4 (wraps), used for link writes
//   instr_out      instruction to decoder (zero outside RUN)
//   instr_valid    instr_out is to be executed this cycle
//   halted         fetch stopped on HALT_INSTR
//   misaligned     sticky fault on a misaligned redirect target
//   instr_count    saturating retired-instruction count
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                        ADDRESS_WIDTH = 8,
    parameter int                        DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
    parameter logic [DATA_WIDTH-1:0]     HALT_INSTR    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     jump,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic                     instr_valid,
    output logic                     halted,
    output logic                     misaligned,
    output logic [15:0]              instr_count
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t                     state, state_next;
    logic [ADDRESS_WIDTH-1:0]   pc, pc_next;
    logic [15:0]                count, count_next;
    logic                       redirect;
    logic [ADDRESS_WIDTH-1:0]   target;
    logic [ADDRESS_WIDTH-1:0]   pc_inc;

    // Natural-width add: the carry out of the top bit is dropped, which is
    // exactly the modulo-2^ADDRESS_WIDTH wrap wanted for the PC.
    assign pc_inc = pc + ADDRESS_WIDTH'(4);

    // NOTE: asynchronous reset and non-blocking assignments keep every
    // register update on one edge, so no block observes a half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            pc    <= RESET_PC;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
        end
    end

    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = count;
        redirect   = 1'b0;
        target     = '0;

        if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end

        case (state)
            S_WAIT: state_next = S_RUN;
            S_RUN: begin
                if (!stall) begin
                    // A halt word wins over any redirect in the same cycle.
                    if (instr_in == HALT_INSTR) begin
                        state_next = S_HALT;
                    end else begin
                        if (count != 16'hFFFF) count_next = count + 16'd1;
                        if (redirect && (target[1:0] != 2'b00)) begin
                            state_next = S_FAULT;
                        end else if (redirect) begin
                            pc_next = target;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                end
            end
            default: ;  // HALT and FAULT only exit through reset
        endcase
    end

    assign pc_out      = pc;
    assign pc_plus4    = pc_inc;
    assign instr_out   = (state == S_RUN) ? instr_in : '0;
    assign instr_valid = (state == S_RUN) && !stall;
    assign halted      = (state == S_HALT);
    assign misaligned  = (state == S_FAULT);
    assign instr_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A small ROM lives in the bench and answers
//   pc_out combinationally. A behavioural model (PC, retire count and three
//   flags: started / stopped-on-halt / stopped-on-fault) is advanced from the
//   architectural rules and compared with the DUT on every falling edge.
//   The stimulus sequence also pins the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic [31:0] instr_in;
    logic [7:0]  pc_out;
    logic [7:0]  pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic        misaligned;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [64];

    fetch_unit #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32),
        .RESET_PC      (8'h00),
        .HALT_INSTR    (HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .misaligned    (misaligned),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: word-indexed by the byte PC.
    assign instr_in = rom[pc_out[7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pc;
    logic [15:0] m_count;
    logic        m_started;
    logic        m_halt;
    logic        m_fault;

    always @(negedge clk) begin
        logic        live;
        logic [31:0] word;
        logic        have_target;
        logic [7:0]  tgt;

        if (!rst_n) begin
            m_pc      = 8'h00;
            m_count   = 16'd0;
            m_started = 1'b0;
            m_halt    = 1'b0;
            m_fault   = 1'b0;
        end

        live = m_started && !m_halt && !m_fault;
        word = rom[m_pc[7:2]];

        check("pc_out",      {24'd0, pc_out},      {24'd0, m_pc});
        check("pc_plus4",    {24'd0, pc_plus4},    {24'd0, 8'(m_pc + 8'd4)});
        check("instr_count", {16'd0, instr_count}, {16'd0, m_count});
        check("instr_out",   instr_out,            live ? word : 32'd0);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, live && !stall});
        check("halted",      {31'd0, halted},      {31'd0, m_halt});
        check("misaligned",  {31'd0, misaligned},  {31'd0, m_fault});

        // Predict the effect of the coming rising edge.
        if (rst_n) begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (live && !stall) begin
                if (word == HALT_WORD) begin
                    m_halt = 1'b1;
                end else begin
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    have_target = jump || branch_taken;
                    tgt         = jump ? jump_target : branch_target;
                    if (have_target && (tgt % 4 != 0)) m_fault = 1'b1;
                    else if (have_target)             m_pc = tgt;
                    else                              m_pc = m_pc + 8'd4;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic j, input logic [7:0] jt,
                        input logic b, input logic [7:0] bt, input logic s);
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        stall         = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1300_0000 + i;
        rom[5] = HALT_WORD;  // byte address 0x14

        rst_n         = 1'b0;
        stall         = 1'b0;
        jump          = 1'b0;
        jump_target   = 8'h00;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc",    {24'd0, pc_out},      32'h0);
        check("reset count", {16'd0, instr_count}, 32'h0);
        check("reset valid", {31'd0, instr_valid}, 32'h0);
        check("reset flags", {30'd0, halted, misaligned}, 32'h0);

        // Release: one edge in WAIT, then RUN at pc 0.
        rst_n = 1'b1;
        idle();
        check("run pc0",     {24'd0, pc_out},      32'h00);
        check("run valid",   {31'd0, instr_valid}, 32'h1);
        check("run instr",   instr_out,            32'h1300_0000);

        // Sequential fetch 0,4,8,C -> lands on 0x10 with four retired.
        repeat (4) idle();
        check("seq pc",      {24'd0, pc_out},      32'h10);
        check("seq count",   {16'd0, instr_count}, 32'd4);

        // Stall three cycles at 0x10 with a jump request that must be ignored.
        jump = 1'b1; jump_target = 8'h40; stall = 1'b1;
        #1;
        check("stall valid", {31'd0, instr_valid}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("stall pc",    {24'd0, pc_out},      32'h10);
        check("stall count", {16'd0, instr_count}, 32'd4);

        // Jump back to 0x08, then jump+branch together: jump wins.
        step(1'b1, 8'h08, 1'b0, 8'h00, 1'b0);
        check("jump pc",     {24'd0, pc_out},      32'h08);
        step(1'b1, 8'h40, 1'b1, 8'h20, 1'b0);
        check("prio pc",     {24'd0, pc_out},      32'h40);
        check("prio count",  {16'd0, instr_count}, 32'd6);

        // Wrap: 0xFC + 4 -> 0x00.
        step(1'b1, 8'hFC, 1'b0, 8'h00, 1'b0);
        check("wrap plus4",  {24'd0, pc_plus4},    32'h00);
        idle();
        check("wrap pc",     {24'd0, pc_out},      32'h00);
        check("wrap count",  {16'd0, instr_count}, 32'd8);

        // Halt at 0x14, with a misaligned branch that same cycle: halt wins.
        step(1'b1, 8'h14, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
        check("halt flag",   {31'd0, halted},      32'h1);
        check("halt nofault",{31'd0, misaligned},  32'h0);
        check("halt pc",     {24'd0, pc_out},      32'h14);
        check("halt count",  {16'd0, instr_count}, 32'd9);
        step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        check("halt hold",   {24'd0, pc_out},      32'h14);

        // Async reset mid-cycle with a jump still requested.
        rst_n = 1'b0;
        #1;
        check("async pc",    {24'd0, pc_out},      32'h00);
        check("async halt",  {31'd0, halted},      32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);  // WAIT edge: jump ignored
        check("wait pc",     {24'd0, pc_out},      32'h00);

        // Misaligned branch target -> sticky fault, PC held.
        step(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
        check("fault flag",  {31'd0, misaligned},  32'h1);
        check("fault pc",    {24'd0, pc_out},      32'h00);
        step(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        idle();
        check("fault hold",  {31'd0, misaligned},  32'h1);

        // Recovery only through reset.
        rst_n = 1'b0;
        #1;
        check("recover flag",{31'd0, misaligned},  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        check("recover pc",  {24'd0, pc_out},      32'h04);
        check("recover cnt", {16'd0, instr_count}, 32'd1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
